// File: rtl/requant_pkg.sv
// Shared widths, output limits and the per-channel parameter record
// used by the requantization stage and its parameter table.
package requant_pkg;

  localparam int ACC_W   = 21;
  localparam int OUT_W   = 8;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;

  localparam int QMAX = 127;
  localparam int QMIN = -128;

  typedef struct packed {
    logic signed [ACC_W-1:0] bias;
    logic [SCALE_W-1:0]      scale;
    logic [SHIFT_W-1:0]      shift;
  } rq_param_t;

  // Identity entry: no bias, unit scale, no shift, so only saturation applies
  localparam rq_param_t RQ_DEFAULT = '{bias: '0, scale: SCALE_W'(1), shift: '0};

endpackage

// File: rtl/requant_param_tbl.sv
// Per-channel requantization parameter table: one synchronous write
// port, one asynchronous read port, reset to identity entries.
module requant_param_tbl
  import requant_pkg::*;
#(
  parameter int NCH = 16,
  parameter int AW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  rq_param_t         wr_data,
  input  logic [AW-1:0]     rd_addr,
  output rq_param_t         rd_data
);

  rq_param_t mem [NCH];

  // Reset restores every entry to identity; otherwise apply the write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mem[i] <= RQ_DEFAULT;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read of the entry being written this cycle still sees the old contents
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/requant_unit.sv
// Requantization stage: bias add, per-channel scale, rounding shift,
// optional ReLU and signed saturation, as a 3-stage pipeline.
module requant_unit #(
  parameter int ACC_W   = requant_pkg::ACC_W,
  parameter int OUT_W   = requant_pkg::OUT_W,
  parameter int SCALE_W = requant_pkg::SCALE_W,
  parameter int SHIFT_W = requant_pkg::SHIFT_W,
  parameter int NCH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_addr,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic [SCALE_W-1:0]       cfg_scale,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     relu_en,
  input  logic                     ch_clr,
  input  logic                     in_vld,
  input  logic signed [ACC_W-1:0]  in_sum,
  output logic                     out_vld,
  output logic signed [OUT_W-1:0]  out_q,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     sat_flag
);
  import requant_pkg::*;

  localparam int AW   = $clog2(NCH);
  localparam int S1_W = ACC_W + 1;
  localparam int PW   = ACC_W + SCALE_W + 2;
  localparam int RW   = PW + 1;
  localparam logic signed [RW-1:0] R_MAX = RW'(QMAX);
  localparam logic signed [RW-1:0] R_MIN = RW'(QMIN);

  logic [AW-1:0] ch;
  logic [AW-1:0] ch_cur;
  rq_param_t     cfg_entry;
  rq_param_t     rd_entry;

  logic                   v1;
  logic signed [S1_W-1:0] s1;
  logic [SCALE_W-1:0]     sc1;
  logic [SHIFT_W-1:0]     sh1;
  logic                   relu1;
  logic [AW-1:0]          ch1;

  logic                   v2;
  logic signed [PW-1:0]   p2;
  logic [SHIFT_W-1:0]     sh2;
  logic                   relu2;
  logic [AW-1:0]          ch2;

  logic signed [RW-1:0]   p_ext;
  logic signed [RW-1:0]   bump;
  logic signed [RW-1:0]   rsum;
  logic signed [RW-1:0]   r;
  logic                   clip_hi;
  logic                   clip_lo;
  logic signed [OUT_W-1:0] q_next;

  assign cfg_entry = '{bias: cfg_bias, scale: cfg_scale, shift: cfg_shift};
  assign ch_cur    = ch_clr ? '0 : ch;

  requant_param_tbl #(.NCH(NCH), .AW(AW)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_entry),
    .rd_addr (ch_cur),
    .rd_data (rd_entry)
  );

  // Channel pointer advances per accepted sample; a clear with a sample lands it on 1
  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
    end else if (in_vld) begin
      ch <= (ch_cur == AW'(NCH - 1)) ? '0 : ch_cur + AW'(1);
    end else if (ch_clr) begin
      ch <= '0;
    end
  end

  // Stage 1: bias add at full width and capture the channel's parameters
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= in_vld;
    if (in_vld) begin
      s1    <= {in_sum[ACC_W-1], in_sum} + {rd_entry.bias[ACC_W-1], rd_entry.bias};
      sc1   <= rd_entry.scale;
      sh1   <= rd_entry.shift;
      relu1 <= relu_en;
      ch1   <= ch_cur;
    end
  end

  // Stage 2: full-precision signed product with the unsigned scale
  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1;
    if (v1) begin
      p2    <= s1 * $signed({1'b0, sc1});
      sh2   <= sh1;
      relu2 <= relu1;
      ch2   <= ch1;
    end
  end

  // Stage 3 datapath: round-half-up shift, ReLU, then saturation detect
  always_comb begin
    p_ext = {p2[PW-1], p2};
    bump  = '0;
    if (sh2 != '0) begin
      bump = RW'(1) << (sh2 - SHIFT_W'(1));
    end
    rsum = p_ext + bump;
    r    = rsum >>> sh2;
    if (relu2 && r[RW-1]) begin
      r = '0;
    end
    clip_hi = (r > R_MAX);
    clip_lo = (r < R_MIN);
    if (clip_hi)      q_next = OUT_W'(QMAX);
    else if (clip_lo) q_next = OUT_W'(QMIN);
    else              q_next = r[OUT_W-1:0];
  end

  // Stage 3 register: output byte holds between samples; clip events win over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      out_ch   <= '0;
      sat_flag <= 1'b0;
    end else begin
      out_vld <= v2;
      if (v2) begin
        out_q  <= q_next;
        out_ch <= ch2;
      end
      if (v2 && (clip_hi || clip_lo)) sat_flag <= 1'b1;
      else if (ch_clr)                sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_requant_unit.sv
// Scoreboard bench for requant_unit: directed samples push their
// hand-computed result; a monitor pops and compares on each out_vld.
module tb_requant_unit;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic signed [20:0] cfg_bias;
  logic [15:0]        cfg_scale;
  logic [4:0]         cfg_shift;
  logic               relu_en;
  logic               ch_clr;
  logic               in_vld;
  logic signed [20:0] in_sum;
  logic               out_vld;
  logic signed [7:0]  out_q;
  logic [3:0]         out_ch;
  logic               sat_flag;

  typedef struct {
    logic signed [7:0] q;
    logic [3:0]        ch;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  requant_unit #(.NCH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_bias (cfg_bias),
    .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift),
    .relu_en  (relu_en),
    .ch_clr   (ch_clr),
    .in_vld   (in_vld),
    .in_sum   (in_sum),
    .out_vld  (out_vld),
    .out_q    (out_q),
    .out_ch   (out_ch),
    .sat_flag (sat_flag)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to check the fixed output latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int sum, input bit clr, input bit relu,
                                input int exp_q, input int exp_ch, input bit expect_out);
    in_vld  = 1'b1;
    in_sum  = 21'(sum);
    ch_clr  = clr;
    relu_en = relu;
    if (expect_out) sb.push_back('{q: 8'(exp_q), ch: 4'(exp_ch), cyc: cyc + 3});
    tick();
    in_vld  = 1'b0;
    ch_clr  = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int bias, input int scale, input int shift, input bit clr);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_bias  = 21'(bias);
    cfg_scale = 16'(scale);
    cfg_shift = 5'(shift);
    ch_clr    = clr;
    tick();
    cfg_we = 1'b0;
    ch_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d outputs still pending, expected 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  // Monitor: every out_vld must match the oldest expectation, on the expected cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_vld === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected_out_vld: got out_q=%0d out_ch=%0d, expected no output", out_q, out_ch);
      end else begin
        e = sb.pop_front();
        check_output("out_q", int'(out_q), int'(e.q));
        check_output("out_ch", int'(out_ch), int'(e.ch));
        check_output("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence
  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_scale = '0; cfg_shift = '0;
    relu_en = 1'b0; ch_clr = 1'b0; in_vld = 1'b0; in_sum = '0;
    tick();
    tick();
    check_output("reset_out_vld", int'(out_vld), 0);
    check_output("reset_out_q", int'(out_q), 0);
    check_output("reset_out_ch", int'(out_ch), 0);
    check_output("reset_sat_flag", int'(sat_flag), 0);
    rst = 1'b0;
    tick();

    // Default table is a pure saturate
    apply_stimulus(100, 0, 0, 100, 0, 1);
    apply_stimulus(300, 0, 0, 127, 1, 1);
    apply_stimulus(-1000, 0, 0, -128, 2, 1);
    drain();
    check_output("sat_after_clip", int'(sat_flag), 1);
    check_output("out_q_hold", int'(out_q), -128);
    ch_clr = 1'b1; tick(); ch_clr = 1'b0;
    check_output("sat_cleared", int'(sat_flag), 0);

    // A clear coinciding with a new clip leaves the flag set
    apply_stimulus(200, 0, 0, 127, 0, 1);
    tick();
    ch_clr = 1'b1; tick(); ch_clr = 1'b0;
    check_output("sat_clip_vs_clr", int'(sat_flag), 1);
    drain();

    // Scale, bias and rounding shift
    cfg_write(0, 50, 3, 2, 1);
    apply_stimulus(10, 0, 0, 45, 0, 1);
    cfg_write(0, 0, 1, 1, 1);
    apply_stimulus(-20, 1, 0, -10, 0, 1);
    apply_stimulus(-21, 1, 0, -10, 0, 1);
    apply_stimulus(9, 0, 0, 9, 1, 1);
    cfg_write(0, 0, 65535, 20, 1);
    apply_stimulus(1000, 1, 0, 62, 0, 1);
    apply_stimulus(-1000, 1, 0, -62, 0, 1);
    cfg_write(0, 1048575, 1, 14, 1);
    apply_stimulus(1048575, 1, 0, 127, 0, 1);
    drain();

    // ReLU zeroes negatives without counting as a clip
    cfg_write(0, 0, 1, 0, 1);
    apply_stimulus(-5, 0, 1, 0, 0, 1);
    apply_stimulus(5, 0, 1, 5, 1, 1);
    apply_stimulus(-300, 0, 1, 0, 2, 1);
    drain();
    check_output("sat_after_relu", int'(sat_flag), 0);

    // Distinct biases per channel, pointer wrap, mid-stream clear
    for (int i = 0; i < 16; i++) cfg_write(i, i, 1, 0, (i == 15));
    for (int i = 0; i < 17; i++) apply_stimulus(0, 0, 0, i % 16, i % 16, 1);
    apply_stimulus(0, 1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 2, 2, 1);
    apply_stimulus(0, 1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1, 1);
    drain();

    // Write in the same cycle as a read of that entry returns the old value
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_bias = 21'sd100; cfg_scale = 16'd1; cfg_shift = 5'd0;
    apply_stimulus(0, 1, 0, 0, 0, 1);
    cfg_we = 1'b0;
    apply_stimulus(0, 1, 0, 100, 0, 1);
    apply_stimulus(1000, 0, 0, 127, 1, 1);
    drain();
    check_output("sat_before_reset", int'(sat_flag), 1);

    // Reset with three samples in flight discards them and restores the table
    apply_stimulus(500, 0, 0, 0, 0, 0);
    apply_stimulus(500, 0, 0, 0, 0, 0);
    rst = 1'b1;
    apply_stimulus(500, 0, 0, 0, 0, 0);
    rst = 1'b0;
    check_output("flush_out_vld", int'(out_vld), 0);
    check_output("flush_out_q", int'(out_q), 0);
    check_output("flush_out_ch", int'(out_ch), 0);
    check_output("flush_sat_flag", int'(sat_flag), 0);
    apply_stimulus(7, 0, 0, 7, 0, 1);
    drain();
    tick();
    check_output("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/requant_unit.md
# requant_unit

Requantization stage between the three-slice accumulator and the 8-bit result register. It takes the 21-bit signed cross-slice sum of each output channel and adds a per-channel bias, then multiplies by a per-channel scale and applies a rounding arithmetic right shift. It then applies optional ReLU and saturates the result to signed 8 bits, producing the `compress` byte that the accumulator stage latches. The pipeline has three stages at one sample per cycle, with a per-channel parameter table loaded through a simple write port.

## Interface

Parameters:
- `ACC_W`, default 21: width of the incoming signed sum.
- `OUT_W`, default 8: width of the signed output.
- `SCALE_W`, default 16: width of the unsigned per-channel scale.
- `SHIFT_W`, default 5: width of the per-channel right-shift amount.
- `NCH`, default 16: parameter-table depth, which is also the channel-pointer modulus.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: parameter-table write strobe.
- `cfg_addr` in `$clog2(NCH)`: table entry to write.
- `cfg_bias` in `ACC_W` signed: bias value.
- `cfg_scale` in `SCALE_W` unsigned: scale multiplier.
- `cfg_shift` in `SHIFT_W`: right-shift amount.
- `relu_en` in 1: global ReLU enable. It is sampled per sample at entry.
- `ch_clr` in 1: returns the channel pointer to 0 and clears `sat_flag`.
- `in_vld` in 1: `in_sum` is valid this cycle.
- `in_sum` in `ACC_W` signed: the accumulated sum for the current channel.
- `out_vld` out 1: `out_q` is valid this cycle.
- `out_q` out `OUT_W` signed: requantized byte.
- `out_ch` out `$clog2(NCH)`: channel index of `out_q`.
- `sat_flag` out 1: sticky flag, set when any output clipped.

## Operation

- Channel pointer `ch`:
  - It increments on every cycle with `in_vld`=1 and wraps from `NCH-1` to 0.
  - If `ch_clr` and `in_vld` occur in the same cycle, the current sample uses channel 0 and the pointer becomes 1.
- Stage 1, on `in_vld`:
  - Read table[`ch`].
  - `s1 = in_sum + bias`, sign-extended to `ACC_W+1` bits.
  - Capture `scale`, `shift`, `relu_en` and `ch` alongside.
- Stage 2: `p = s1 * $signed({1'b0, scale})`, full `ACC_W+SCALE_W+2` bit product, no truncation.
- Stage 3:
  - If `shift`=0, `r = p`.
  - Otherwise `r = (p + (1 << (shift-1))) >>> shift`, which is round-half-up.
  - If `relu_en` and `r < 0`, then `r = 0`.
  - Clip `r` to [-128, 127] and register the result into `out_q`. Clipping sets `sat_flag`.
- `sat_flag` holds until `rst` or `ch_clr`. A `ch_clr` in the same cycle as a new clip event leaves the flag set.
- Table write:
  - It takes effect at the clock edge.
  - A read of the same address in the same cycle returns the old value.
  - In-flight samples keep the parameters they captured at stage 1.
- Reset:
  - All pipeline valids, `out_vld`, `out_q`, `out_ch`, `ch` and `sat_flag` go to 0.
  - Every table entry goes to bias=0, scale=1, shift=0, so the post-reset transfer function is a pure saturate.
  - Samples in flight when `rst` asserts are discarded; no `out_vld` is produced for them.

## Timing

- Latency is fixed at 3 cycles: `in_vld` in cycle N gives `out_vld` in cycle N+3.
- Throughput is 1 sample per cycle. There is no backpressure and no stall; the downstream stage must be able to accept every `out_vld`.
- Gaps in `in_vld` propagate unchanged as bubbles.
- `out_q` and `out_ch` hold their last values while `out_vld`=0.
- Asserting `ch_clr` alone does not affect the pipeline contents.

## Structure

- Shared package `requant_pkg` holds:
  - the `ACC_W`, `OUT_W`, `SCALE_W`, `SHIFT_W` localparams;
  - the `QMAX`=127 and `QMIN`=-128 constants;
  - a packed struct `rq_param_t` {bias, scale, shift}.
- One sub-module, `requant_param_tbl`: `NCH` entries of `rq_param_t`, one write port, one asynchronous read port, synchronous reset to the default entries.
- The arithmetic pipeline stays in the top module.

## Test plan

- After reset, with default table: `in_sum` = 100, then 300, then -1000 on consecutive cycles → `out_q` = 100, 127, -128 in cycles N+3..N+5, and `sat_flag`=1 from cycle N+4.
- Channel 0 programmed with bias=50, scale=3, shift=2: `in_sum`=10 → 45 (0x2D). With bias=0, scale=1, shift=1: `in_sum`=-20 → -10. `in_sum`=-21 → -10 (round half up).
- `relu_en`=1 with default table: `in_sum`=-5 → 0 and `sat_flag` unchanged. `in_sum`=5 → 5.
- Program channels 0..15 with distinct biases (0, 1, …, 15), then send 17 back-to-back samples of 0 → outputs 0..15 then 0, with `out_ch` wrapping to 0, one output per cycle. A `ch_clr` pulse mid-stream restarts `out_ch` at 0 for the next sample.
- Write table[0].bias=100 in the same cycle as `in_vld` on channel 0 with `in_sum`=0 → output uses the old bias 0. The next channel-0 sample uses 100.
- Assert `rst` for one cycle while 3 samples are in flight → no `out_vld` for any of them; `out_q`=0, `sat_flag`=0, `ch`=0 and the table back to defaults, so the next `in_sum`=7 returns 7.
